// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: runs one register-to-register op per command against a RegistersFile
// (read both operands, execute, write back, pulse done).
module rf_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rs, r_rt, r_rd, r_write_reg;
    logic [DATA_W-1:0] r_imm, r_a, r_b, r_result;
    logic              r_ovf;
    logic [DATA_W-1:0] w_sum, w_diff, w_alu;
    logic              w_ovf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = cmd_valid ? S_READ : S_IDLE;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (r_op)
            3'd0: begin
                w_alu = w_sum;
                w_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            3'd1: begin
                w_alu = w_diff;
                w_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            3'd2: w_alu = r_a & r_b;
            3'd3: w_alu = r_a | r_b;
            3'd4: w_alu = r_a ^ r_b;
            3'd5: w_alu = {{(DATA_W-1){1'b0}}, $signed(r_a) < $signed(r_b)};
            3'd6: w_alu = r_a << r_b[4:0];
            default: w_alu = r_imm;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_write_reg <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cmd_valid) begin
                r_op  <= cmd_op;
                r_rs  <= cmd_rs;
                r_rt  <= cmd_rt;
                r_rd  <= cmd_rd;
                r_imm <= cmd_imm;
            end
            if (r_state == S_READ) begin
                r_a <= read_data1;
                r_b <= read_data2;
            end
            if (r_state == S_EXEC) begin
                r_result    <= w_alu;
                r_ovf       <= w_ovf;
                r_write_reg <= r_rd;
            end
        end
    end

    // write_enable decodes straight from state so an async reset kills it at once
    assign cmd_ready    = (r_state == S_IDLE);
    assign done         = (r_state == S_DONE);
    assign write_enable = (r_state == S_WRITE) && (r_write_reg != '0);
    assign read_reg1    = r_rs;
    assign read_reg2    = r_rt;
    assign write_reg    = r_write_reg;
    assign write_data   = r_result;
    assign result       = r_result;
    assign ovf          = r_ovf;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: drives rf_op_sequencer against a behavioural register file and
// checks every command against an arithmetic reference model.
module tb_rf_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [31:0] cmd_imm = '0;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] read_data1, read_data2, write_data, result;
    logic        write_enable, done, ovf;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(read_data1), .read_data2(read_data2),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .done(done), .result(result), .ovf(ovf)
    );

    // Register file environment: combinational reads, commit on the rising edge.
    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];
    always @(posedge clk) begin
        if (write_enable) rf[write_reg] <= write_data;
        else if (poke_en) rf[poke_addr] <= poke_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s = 0;
        logic [31:0] res = '0;
        logic o = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; res = a + b; end
            3'd1: begin s = sa - sb; res = a - b; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: res = a << b[4:0];
            default: res = imm;
        endcase
        if (op <= 3'd1) o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {o, res};
    endfunction

    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        exp_rf[a] = d;
    endtask

    // Issue one command and check handshake, timing, write port, result and commit.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] imm,
                           output logic [31:0] res, output logic ov);
        logic [32:0] m;
        int n = 0, dones = 0, wes = 0, rdy = 0;
        m = model(op, exp_rf[rs], exp_rf[rt], imm);
        res = '0; ov = 1'b0;
        @(negedge clk);
        while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (write_enable) wes++;
            if (done) dones++;
            if (i <= 4 && cmd_ready) rdy++;
            if (i == 1) begin
                chk({tag, "_rreg1"}, read_reg1, rs);
                chk({tag, "_rreg2"}, read_reg2, rt);
            end
            if (i == 3) begin
                chk({tag, "_we"}, write_enable, rd != 0);
                chk({tag, "_wreg"}, write_reg, rd);
                chk({tag, "_wdata"}, write_data, m[31:0]);
            end
            if (i == 4) begin
                chk({tag, "_done"}, done, 1'b1);
                chk({tag, "_result"}, result, m[31:0]);
                chk({tag, "_ovf"}, ovf, m[32]);
                res = result; ov = ovf;
                if (rd != 0) exp_rf[rd] = m[31:0];
                chk({tag, "_rf_rd"}, rf[rd], exp_rf[rd]);
                chk({tag, "_rf_r0"}, rf[0], 32'd0);
            end
        end
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_we_count"}, wes, (rd != 0) ? 1 : 0);
        chk({tag, "_busy_ready"}, rdy, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, imm, res;
        logic        ov;
    } vec_t;

    initial begin
        vec_t tbl[11];
        logic [31:0] r;
        logic o;
        int acc[$];

        tbl[0]  = '{3'd0, 32'd7,          32'd5,          32'd0,      32'd12,         1'b0};
        tbl[1]  = '{3'd1, 32'd7,          32'd5,          32'd0,      32'd2,          1'b0};
        tbl[2]  = '{3'd0, 32'h7FFFFFFF,   32'd1,          32'd0,      32'h80000000,   1'b1};
        tbl[3]  = '{3'd1, 32'h80000000,   32'd1,          32'd0,      32'h7FFFFFFF,   1'b1};
        tbl[4]  = '{3'd2, 32'h0000F0F0,   32'h0000FF00,   32'd0,      32'h0000F000,   1'b0};
        tbl[5]  = '{3'd3, 32'h0000F0F0,   32'h0000FF00,   32'd0,      32'h0000FFF0,   1'b0};
        tbl[6]  = '{3'd4, 32'h0000F0F0,   32'h0000FF00,   32'd0,      32'h00000FF0,   1'b0};
        tbl[7]  = '{3'd5, 32'hFFFFFFFF,   32'd1,          32'd0,      32'd1,          1'b0};
        tbl[8]  = '{3'd5, 32'd1,          32'hFFFFFFFF,   32'd0,      32'd0,          1'b0};
        tbl[9]  = '{3'd6, 32'd1,          32'd35,         32'd0,      32'd8,          1'b0};
        tbl[10] = '{3'd7, 32'd3,          32'd4,          32'h1234,   32'h1234,       1'b0};

        #2;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_rreg1", read_reg1, 32'd0);
        chk("rst_rreg2", read_reg2, 32'd0);
        chk("rst_wreg", write_reg, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) set_reg(5'(i), (i == 0) ? 32'd0 : $urandom);

        for (int i = 0; i < 11; i++) begin
            set_reg(5'd1, tbl[i].a);
            set_reg(5'd2, tbl[i].b);
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, 5'd1, 5'd2, 5'd3, tbl[i].imm, r, o);
            chk($sformatf("tbl%0d_res_const", i), r, tbl[i].res);
            chk($sformatf("tbl%0d_ovf_const", i), o, tbl[i].ov);
        end

        run_cmd("ldi20", 3'd7, 5'd0, 5'd0, 5'd20, 32'd10, r, o);
        chk("ldi20_rf", rf[20], 32'd10);

        set_reg(5'd1, 32'd7);
        set_reg(5'd2, 32'd5);
        run_cmd("add3", 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, r, o);
        run_cmd("sub4", 3'd1, 5'd3, 5'd2, 5'd4, 32'd0, r, o);
        chk("r3_val", rf[3], 32'd12);
        chk("r4_val", rf[4], 32'd7);

        set_reg(5'd1, 32'h7FFFFFFF);
        set_reg(5'd2, 32'd1);
        run_cmd("ovf_add", 3'd0, 5'd1, 5'd2, 5'd5, 32'd0, r, o);
        chk("ovf_add_res", r, 32'h80000000);
        chk("ovf_add_flag", o, 1'b1);
        run_cmd("slt_r5", 3'd5, 5'd5, 5'd2, 5'd7, 32'd0, r, o);
        chk("slt_r5_res", r, 32'd1);

        run_cmd("ldi_r0", 3'd7, 5'd0, 5'd0, 5'd0, 32'hDEAD, r, o);
        chk("ldi_r0_res", r, 32'hDEAD);
        chk("ldi_r0_rf", rf[0], 32'd0);

        // Reset asserted in the middle of WRITE must suppress the commit.
        set_reg(5'd6, 32'h55);
        @(negedge clk);
        cmd_op = 3'd0; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd6; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_we_before", write_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we_after", write_enable, 1'b0);
        chk("mid_ready", cmd_ready, 1'b1);
        chk("mid_done", done, 1'b0);
        chk("mid_result", result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_r6", rf[6], 32'h55);
        @(negedge clk);
        chk("post_ready", cmd_ready, 1'b1);
        chk("post_done", done, 1'b0);

        // cmd_valid held high with changing commands: accepts only every 5 cycles.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            cmd_op = 3'd7; cmd_rs = 5'(i); cmd_rt = 5'(i + 1);
            cmd_rd = 5'(8 + (i % 16)); cmd_imm = 32'(100 + i); cmd_valid = 1'b1;
            if (cmd_ready) acc.push_back(i);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("stream_accepts", acc.size(), 6);
        for (int k = 1; k < acc.size(); k++) chk($sformatf("stream_gap%0d", k), acc[k] - acc[k-1], 5);
        foreach (acc[k]) exp_rf[8 + (acc[k] % 16)] = 32'(100 + acc[k]);
        for (int i = 8; i < 24; i++) chk($sformatf("stream_rf%0d", i), rf[i], exp_rf[i]);

        for (int i = 0; i < 40; i++)
            run_cmd($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                    5'($urandom), $urandom, r, o);

        for (int i = 0; i < 32; i++) chk($sformatf("final_rf%0d", i), rf[i], exp_rf[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
